// File: rtl/run_monitor_pkg.sv
// Shared definitions for the run_monitor slice: FSM state encoding,
// default mailbox constants and the sticky result-flag bundle.
package run_monitor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] MAILBOX_ADDR_DEF = 32'h0000_00FC;
    localparam logic [31:0] PASS_VAL_DEF     = 32'h0000_0001;

    typedef struct packed {
        logic pass;
        logic fail;
        logic hang;
        logic timeout;
    } flags_t;

    localparam flags_t FLAGS_CLEAR = 4'b0000;

endpackage

// File: rtl/run_monitor_if.sv
// Core-side bus between a MIPS core and its run monitor: fetch pc,
// data-memory store port, and the monitor-driven core reset.
interface run_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              memwrite;
    logic [ADDR_W-1:0] aluout;
    logic [DATA_W-1:0] writedata;
    logic              core_reset;

    modport master (
        output pc,
        output memwrite,
        output aluout,
        output writedata,
        input  core_reset
    );

    modport slave (
        input  pc,
        input  memwrite,
        input  aluout,
        input  writedata,
        output core_reset
    );
endinterface

// File: rtl/pc_stall_detector.sv
// Flags a core whose pc has stayed at one value for STALL_LIMIT consecutive
// enabled samples; the stall output is a single-cycle pulse on that sample.
module pc_stall_detector #(
    parameter int ADDR_W      = 32,
    parameter int STALL_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [ADDR_W-1:0] pc,
    output logic              stall
);

    localparam int SW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [SW-1:0] CNT_FIRE = SW'(STALL_LIMIT - 2);
    localparam logic [SW-1:0] CNT_SAT  = SW'(STALL_LIMIT - 1);
    localparam logic [SW-1:0] CNT_ONE  = {{(SW-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] prev_pc_r;
    logic              prev_valid_r;
    logic [SW-1:0]     cnt_r;
    logic              same_s;

    // The first sample after a clear has no predecessor, so it never counts as a repeat.
    assign same_s = prev_valid_r && (pc == prev_pc_r);
    assign stall  = enable && same_s && (cnt_r == CNT_FIRE);

    // Previous-pc register and saturating repeat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc_r    <= '0;
            prev_valid_r <= 1'b0;
            cnt_r        <= '0;
        end else if (clear) begin
            prev_pc_r    <= '0;
            prev_valid_r <= 1'b0;
            cnt_r        <= '0;
        end else if (enable) begin
            prev_pc_r    <= pc;
            prev_valid_r <= 1'b1;
            if (same_s) begin
                cnt_r <= (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CNT_ONE;
            end else begin
                cnt_r <= '0;
            end
        end else begin
            prev_pc_r    <= prev_pc_r;
            prev_valid_r <= prev_valid_r;
            cnt_r        <= cnt_r;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run controller for a MIPS core: holds the core in reset after start, then
// watches for a mailbox store, a hung pc or an exhausted cycle budget.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 100,
    parameter int HOLD_CYCLES = 2,
    parameter int STALL_LIMIT = 8,
    parameter logic [ADDR_W-1:0] MAILBOX_ADDR = ADDR_W'(MAILBOX_ADDR_DEF),
    parameter logic [DATA_W-1:0] PASS_VAL     = DATA_W'(PASS_VAL_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    run_monitor_if.slave      core,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              hang,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W-1:0] end_pc
);

    generate
        if (MAX_CYCLES < 1 || (MAX_CYCLES >> CNT_W) != 0 ||
            HOLD_CYCLES < 1 || STALL_LIMIT < 2) begin : g_bad_params
            $error("run_monitor: illegal MAX_CYCLES/CNT_W/HOLD_CYCLES/STALL_LIMIT combination");
        end
    endgenerate

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_r, state_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic [ADDR_W-1:0] end_pc_r, end_pc_s;
    flags_t            flags_r, flags_s;
    logic              core_reset_r;
    logic              running_r;
    logic              done_r;
    logic              mailbox_hit_s;
    logic              in_run_s;
    logic              stall_s;

    assign in_run_s      = (state_r == ST_RUN);
    assign mailbox_hit_s = core.memwrite && (core.aluout == MAILBOX_ADDR);

    pc_stall_detector #(
        .ADDR_W      (ADDR_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_run_s),
        .enable (in_run_s),
        .pc     (core.pc),
        .stall  (stall_s)
    );

    // Next-state logic; terminating events in RUN are resolved mailbox > hang > timeout.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        count_s    = count_r;
        end_pc_s   = end_pc_r;
        flags_s    = flags_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s    = ST_HOLD;
                    hold_cnt_s = HOLD_LOAD;
                    count_s    = '0;
                    end_pc_s   = '0;
                    flags_s    = FLAGS_CLEAR;
                end else begin
                    state_s = state_r;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == '0) begin
                    state_s = ST_RUN;
                    count_s = CNT_ONE;
                end else begin
                    hold_cnt_s = hold_cnt_r - HOLD_ONE;
                end
            end
            ST_RUN: begin
                if (mailbox_hit_s) begin
                    flags_s.pass = (core.writedata == PASS_VAL);
                    flags_s.fail = (core.writedata != PASS_VAL);
                    end_pc_s     = core.pc;
                    state_s      = ST_DONE;
                end else if (stall_s) begin
                    flags_s.hang = 1'b1;
                    end_pc_s     = core.pc;
                    state_s      = ST_DONE;
                end else if (count_r == MAX_CNT) begin
                    flags_s.timeout = 1'b1;
                    end_pc_s        = core.pc;
                    state_s         = ST_DONE;
                end else begin
                    count_s = count_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; the core is held in reset everywhere except RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            hold_cnt_r   <= '0;
            count_r      <= '0;
            end_pc_r     <= '0;
            flags_r      <= FLAGS_CLEAR;
            core_reset_r <= 1'b1;
            running_r    <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            hold_cnt_r   <= hold_cnt_s;
            count_r      <= count_s;
            end_pc_r     <= end_pc_s;
            flags_r      <= flags_s;
            core_reset_r <= (state_s != ST_RUN);
            running_r    <= (state_s == ST_RUN);
            done_r       <= (state_s == ST_DONE);
        end
    end

    assign core.core_reset = core_reset_r;
    assign running         = running_r;
    assign done            = done_r;
    assign pass            = flags_r.pass;
    assign fail            = flags_r.fail;
    assign hang            = flags_r.hang;
    assign timeout         = flags_r.timeout;
    assign cycle_count     = count_r;
    assign end_pc          = end_pc_r;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: stimulus pushes the expected run result,
// a monitor pops and compares it whenever done rises.
module tb_run_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        running, done, pass, fail, hang, timeout;
    logic [15:0] cycle_count;
    logic [31:0] end_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        p;
        logic        f;
        logic        h;
        logic        t;
        logic [15:0] cnt;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];

    run_monitor_if #(.ADDR_W(32), .DATA_W(32)) core_bus ();

    run_monitor #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .CNT_W       (16),
        .MAX_CYCLES  (100),
        .HOLD_CYCLES (2),
        .STALL_LIMIT (8),
        .MAILBOX_ADDR(32'h0000_00FC),
        .PASS_VAL    (32'h0000_0001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .core       (core_bus),
        .running    (running),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .hang       (hang),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .end_pc     (end_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle(input logic [31:0] p, input logic mw,
                             input logic [31:0] a, input logic [31:0] wd);
        core_bus.pc        = p;
        core_bus.memwrite  = mw;
        core_bus.aluout    = a;
        core_bus.writedata = wd;
        cycle();
    endtask

    task automatic push_exp(input logic p, input logic f, input logic h, input logic t,
                            input logic [15:0] cnt, input logic [31:0] epc);
        exp_t e;
        e.p = p; e.f = f; e.h = h; e.t = t; e.cnt = cnt; e.epc = epc;
        exp_q.push_back(e);
    endtask

    // Start pulse, then the two HOLD cycles, ending in run cycle 1.
    task automatic start_run();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("hold0_core_reset", core_bus.core_reset, 1'b1);
        chk("hold0_flags_clear", {pass, fail, hang, timeout, done}, 5'b00000);
        chk("hold0_count_clear", cycle_count, 16'd0);
        chk("hold0_end_pc_clear", end_pc, 32'h0);
        cycle();
        chk("hold1_core_reset", core_bus.core_reset, 1'b1);
        cycle();
        chk("run1_core_reset", core_bus.core_reset, 1'b0);
        chk("run1_running", running, 1'b1);
        chk("run1_count", cycle_count, 16'd1);
    endtask

    initial begin : monitor
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=done expected=no_result_pending at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pass", pass, e.p);
                    chk("sb_fail", fail, e.f);
                    chk("sb_hang", hang, e.h);
                    chk("sb_timeout", timeout, e.t);
                    chk("sb_cycle_count", cycle_count, e.cnt);
                    chk("sb_end_pc", end_pc, e.epc);
                    chk("sb_core_reset", core_bus.core_reset, 1'b1);
                end
            end
            done_q = done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=still_running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset              = 1'b0;
        start              = 1'b0;
        core_bus.pc        = 32'h0;
        core_bus.memwrite  = 1'b0;
        core_bus.aluout    = 32'h0;
        core_bus.writedata = 32'h0;

        repeat (3) cycle();
        chk("rst_core_reset", core_bus.core_reset, 1'b1);
        chk("rst_outputs", {running, done, pass, fail, hang, timeout}, 6'b000000);
        reset = 1'b1;

        // Mailbox stores while IDLE must be ignored.
        for (int i = 0; i < 20; i++) begin
            run_cycle(32'h0000_0010 + 32'(i), (i < 4), 32'h0000_00FC, 32'h0000_0001);
        end
        chk("idle_core_reset", core_bus.core_reset, 1'b1);
        chk("idle_flags", {running, done, pass, fail, hang, timeout}, 6'b000000);
        chk("idle_count", cycle_count, 16'd0);
        chk("idle_end_pc", end_pc, 32'h0);

        // Pass run: foreign-address store at cycle 3, mailbox pass at cycle 10.
        start_run();
        for (int k = 1; k <= 9; k++) begin
            run_cycle(32'h0000_0100 + 32'(4 * k), (k == 3), 32'h0000_0080, 32'h0000_0001);
        end
        chk("pass_pre_count", cycle_count, 16'd10);
        chk("pass_pre_running", running, 1'b1);
        push_exp(1'b1, 1'b0, 1'b0, 1'b0, 16'd10, 32'h0000_0128);
        run_cycle(32'h0000_0128, 1'b1, 32'h0000_00FC, 32'h0000_0001);
        chk("pass_done", done, 1'b1);
        chk("pass_running_low", running, 1'b0);
        run_cycle(32'h0000_0130, 1'b1, 32'h0000_00FC, 32'h0000_0007);
        chk("done_store_ignored", {pass, fail}, 2'b10);
        chk("done_count_hold", cycle_count, 16'd10);

        // Fail wins over a simultaneous hang (8th identical pc sample).
        start_run();
        for (int k = 1; k <= 7; k++) begin
            run_cycle(32'h0000_0200, 1'b0, 32'h0, 32'h0);
        end
        chk("prio_not_yet_hang", {running, hang}, 2'b10);
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, 16'd8, 32'h0000_0200);
        run_cycle(32'h0000_0200, 1'b1, 32'h0000_00FC, 32'h0000_0007);
        chk("prio_done", done, 1'b1);

        // Hang: pc stuck at 0x40 from run cycle 3; start mid-run is ignored.
        start_run();
        run_cycle(32'h0000_0300, 1'b0, 32'h0, 32'h0);
        start = 1'b1;
        run_cycle(32'h0000_0304, 1'b0, 32'h0, 32'h0);
        start = 1'b0;
        chk("midrun_start_running", {running, core_bus.core_reset}, 2'b10);
        chk("midrun_start_count", cycle_count, 16'd3);
        for (int k = 3; k <= 9; k++) begin
            run_cycle(32'h0000_0040, 1'b0, 32'h0, 32'h0);
        end
        chk("hang_7_samples_running", running, 1'b1);
        push_exp(1'b0, 1'b0, 1'b1, 1'b0, 16'd10, 32'h0000_0040);
        run_cycle(32'h0000_0040, 1'b0, 32'h0, 32'h0);
        chk("hang_done", done, 1'b1);
        chk("hang_core_reset", core_bus.core_reset, 1'b1);

        // Timeout after 100 run cycles of incrementing pc.
        start_run();
        for (int k = 1; k <= 99; k++) begin
            run_cycle(32'h0000_1000 + 32'(4 * k), 1'b0, 32'h0, 32'h0);
        end
        chk("tmo_pre_count", cycle_count, 16'd100);
        chk("tmo_pre_running", {running, timeout}, 2'b10);
        push_exp(1'b0, 1'b0, 1'b0, 1'b1, 16'd100, 32'h0000_1190);
        run_cycle(32'h0000_1190, 1'b0, 32'h0, 32'h0);
        chk("tmo_done", {done, timeout}, 2'b11);
        run_cycle(32'h0000_1194, 1'b0, 32'h0, 32'h0);
        chk("tmo_count_hold", cycle_count, 16'd100);

        // Restart from DONE, then reset asynchronously in run cycle 40.
        start_run();
        for (int k = 1; k <= 39; k++) begin
            run_cycle(32'h0000_2000 + 32'(4 * k), 1'b0, 32'h0, 32'h0);
        end
        chk("rst_mid_pre_count", cycle_count, 16'd40);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_core_reset", core_bus.core_reset, 1'b1);
        chk("rst_mid_count", cycle_count, 16'd0);
        chk("rst_mid_flags", {running, done, pass, fail, hang, timeout}, 6'b000000);
        cycle();
        reset = 1'b1;
        repeat (3) cycle();
        chk("post_rst_idle", {core_bus.core_reset, running, done}, 3'b100);
        chk("sb_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
